adc_spi_responder: RTL and testbench

- Synthesizable SPI responder emulating a 12-bit serial ADC (PmodAD1-style, 16-bit frame: 4 leading zeros then 12 data bits MSB first).
- Is the other end of the potentiometer reader's serial link: drives the data line that `read_potentiometer` samples.
- Used to loop one board port back into the game (e.g. JB to JA) and as a synthesizable stand-in during bring-up.
- Serves a parallel sample from the fabric, synchronizes the master's `cs_n`/`sclk` into its own clock domain, and reports completed frames.

---
 rtl/adc_spi_responder_pkg.sv | 14 +
 rtl/adc_spi_responder_pin_sync.sv | 38 +++
 rtl/adc_spi_responder.sv | 154 +++++++++++++++
 tb/tb_adc_spi_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the serial ADC responder: FSM state codes and frame geometry.
package adc_spi_responder_pkg;

    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned COUNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/adc_spi_responder_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin, followed by a registered edge detector.
module pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    // level_q is the extra flop behind the synchronizer; edges compare it against the last stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            level_q <= sync_q[SYNC_STAGES-1];
            rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 12-bit serial ADC: serves the held sample as a
// zero-led 16-bit frame, shifting on master sclk falls seen through synchronizers.
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned LEAD_ZEROS  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  sample,
    input  logic               sample_valid,
    input  logic               cs_n,
    input  logic               sclk,
    output logic               sdata,
    output logic               sdata_oe,
    output logic               busy,
    output logic               frame_done,
    output logic [COUNT_W-1:0] frame_count
);

    localparam int unsigned FRAME_W = LEAD_ZEROS + DATA_W;

    logic cs_rise;
    logic cs_fall;
    logic cs_level_unused;
    logic sclk_fall;
    logic sclk_rise_unused;
    logic sclk_level_unused;

    pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (cs_n),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise_unused),
        .fall  (sclk_fall)
    );

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    hold_q, hold_d;
    logic                 sdata_q, sdata_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [FRAME_W-1:0]   load_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            hold_q    <= '0;
            sdata_q   <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            sdata_q   <= sdata_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sdata_d   = sdata_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        count_d   = count_q;
        hold_d    = sample_valid ? sample : hold_q;
        // a sample arriving on the frame-start cycle bypasses the hold register
        load_word = FRAME_W'(sample_valid ? sample : hold_q);

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shift_d   = load_word;
                    bit_cnt_d = '0;
                    sdata_d   = load_word[FRAME_W-1];
                    oe_d      = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // chip-select release wins over a coincident sclk fall, even the last one
                if (cs_rise) begin
                    oe_d    = 1'b0;
                    sdata_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (sclk_fall) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        oe_d    = 1'b0;
                        sdata_d = 1'b0;
                        done_d  = 1'b1;
                        count_d = count_q + COUNT_W'(1);
                        state_d = ST_HOLD;
                    end else begin
                        sdata_d = shift_q[FRAME_W-2];
                    end
                end
            end
            ST_HOLD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                oe_d    = 1'b0;
                sdata_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign sdata       = sdata_q;
    assign sdata_oe    = oe_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a bench-side SPI master plus a frame-level model
// of the responder, compared against the DUT outputs every clock.
module tb_adc_spi_responder;
    import adc_spi_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b1;
    logic        sdata;
    logic        sdata_oe;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_count;

    adc_spi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sdata        (sdata),
        .sdata_oe     (sdata_oe),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: pins take 4 clocks from sampling to visible effect (2 sync + edge flop + output flop),
    // so at each edge the model reacts to the transition between samples n-4 and n-3.
    int          m_mode;   // 0 idle, 1 shifting, 2 frame complete, waiting for cs_n release
    int          m_bits;
    logic [15:0] m_word;
    logic [11:0] m_hold;
    logic [11:0] m_src;
    logic [7:0]  m_count;
    logic        m_done;
    logic [4:0]  cs_h;
    logic [4:0]  sc_h;
    logic        exp_sd;

    always begin
        @(posedge clk);
        if (reset) begin
            m_mode  = 0;
            m_bits  = 0;
            m_word  = '0;
            m_hold  = '0;
            m_count = '0;
            m_done  = 1'b0;
            cs_h    = '1;
            sc_h    = '1;
        end else begin
            cs_h   = {cs_h[3:0], cs_n};
            sc_h   = {sc_h[3:0], sclk};
            m_done = 1'b0;
            m_src  = sample_valid ? sample : m_hold;
            case (m_mode)
                0: if (cs_h[4] && !cs_h[3]) begin
                    m_word = {4'h0, m_src};
                    m_bits = 0;
                    m_mode = 1;
                end
                1: if (!cs_h[4] && cs_h[3]) begin
                    m_mode = 0;
                end else if (sc_h[4] && !sc_h[3]) begin
                    m_bits++;
                    if (m_bits == FRAME_LEN) begin
                        m_mode  = 2;
                        m_done  = 1'b1;
                        m_count = m_count + 8'd1;
                    end
                end
                2: if (!cs_h[4] && cs_h[3]) m_mode = 0;
                default: m_mode = 0;
            endcase
            if (sample_valid) m_hold = sample;
        end
        #1;
        exp_sd = 1'b0;
        if (m_mode == 1) exp_sd = m_word[15 - m_bits];
        chk("sdata", 32'(sdata), 32'(exp_sd));
        chk("sdata_oe", 32'(sdata_oe), 32'(m_mode == 1));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_count", 32'(frame_count), 32'(m_count));
        if (frame_done === 1'b1) done_seen++;
    end

    task automatic load(input logic [11:0] v);
        sample = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_sample(input int dly, input logic [11:0] v);
        repeat (dly) @(negedge clk);
        sample = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Master: bit i is taken late in sclk high phase i (before fall i+1); simul raises cs_n on the last fall.
    task automatic run_frame(input int n_falls, input int half, input int lead, input bit simul,
                             output logic [15:0] got);
        got = '0;
        cs_n = 1'b0;
        repeat (lead) @(negedge clk);
        for (int i = 0; i < n_falls; i++) begin
            got[15 - i] = sdata;
            sclk = 1'b0;
            if (simul && i == n_falls - 1) cs_n = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (half + 2) @(negedge clk);
    endtask

    logic [15:0] got;
    int          full;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_oe", 32'(sdata_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);

        // basic frame at sclk = clk/16
        load(12'hA5C);
        done_seen = 0;
        run_frame(16, 8, 6, 1'b0, got);
        chk("frame_word", 32'(got), 32'h0A5C);
        chk("frame_done_pulses", 32'(done_seen), 32'd1);
        chk("frame_count_1", 32'(frame_count), 32'd1);
        chk("frame_oe_after", 32'(sdata_oe), 32'd0);

        // bypass: sample_valid on the cycle the cs_n fall is recognized
        load(12'h001);
        fork pulse_sample(3, 12'h3FF); join_none
        run_frame(16, 6, 6, 1'b0, got);
        chk("bypass_word", 32'(got), 32'h03FF);
        chk("bypass_count", 32'(frame_count), 32'd2);

        // abort after 7 falls, then a clean frame
        load(12'h7E1);
        done_seen = 0;
        run_frame(7, 6, 6, 1'b0, got);
        chk("abort_done", 32'(done_seen), 32'd0);
        chk("abort_count", 32'(frame_count), 32'd2);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_oe", 32'(sdata_oe), 32'd0);
        run_frame(16, 6, 6, 1'b0, got);
        chk("after_abort_word", 32'(got), 32'h07E1);
        chk("after_abort_count", 32'(frame_count), 32'd3);

        // cs_n rise coincident with the 16th sclk fall is an abort
        done_seen = 0;
        run_frame(16, 6, 6, 1'b1, got);
        chk("simul_done", 32'(done_seen), 32'd0);
        chk("simul_count", 32'(frame_count), 32'd3);
        chk("simul_busy", 32'(busy), 32'd0);

        // hold update during a frame only affects the next frame
        load(12'h123);
        fork pulse_sample(40, 12'hABC); join_none
        run_frame(16, 6, 6, 1'b0, got);
        chk("midupd_cur_word", 32'(got), 32'h0123);
        run_frame(16, 6, 6, 1'b0, got);
        chk("midupd_next_word", 32'(got), 32'h0ABC);
        chk("midupd_count", 32'(frame_count), 32'd5);

        // asynchronous reset after 9 falls
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            sclk = 1'b0;
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            repeat (6) @(negedge clk);
        end
        chk("pre_reset_oe", 32'(sdata_oe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_sdata", 32'(sdata), 32'd0);
        chk("async_rst_oe", 32'(sdata_oe), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(frame_done), 32'd0);
        chk("async_rst_count", 32'(frame_count), 32'd0);
        cs_n = 1'b1;
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_frame(16, 6, 6, 1'b0, got);
        chk("post_reset_word", 32'(got), 32'h0000);
        chk("post_reset_count", 32'(frame_count), 32'd1);

        // randomized frames, aborts and hold updates until the counter wraps
        full = 1;
        while (full < 256) begin
            automatic int half = int'($urandom_range(7, 5));
            automatic int lead = int'($urandom_range(8, 5));
            if ($urandom_range(3, 0) == 0) begin
                automatic int dly = int'($urandom_range(150, 1));
                automatic logic [11:0] v = 12'($urandom);
                fork pulse_sample(dly, v); join_none
            end
            if ($urandom_range(7, 0) == 0) begin
                run_frame(int'($urandom_range(15, 1)), half, lead, 1'b0, got);
            end else begin
                run_frame(16, half, lead, 1'b0, got);
                full++;
            end
        end
        repeat (200) @(negedge clk);
        chk("wrap_count", 32'(frame_count), 32'd0);
        chk("wrap_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
